mix_columns: RTL and testbench
==============================

// Module: mix_columns
// PURPOSE
//  AES MixColumns round stage; sits directly downstream of ShiftRows and consumes its
//  valid_out/data_out pair. Processes one 128-bit state column-serially (one 32-bit
//  column per clock) under a valid/ready handshake. Has a per-block bypass for the
//  final AES round, which skips MixColumns.
// PARAMETERS
//  DATA_W   128  state width; only 128 is supported (elaboration error otherwise)
//  NB       4    columns per state; column width = DATA_W/NB = 32
// PORTS
//  clk        in   1       single clock, all logic on posedge
//  reset      in   1       synchronous, active-high reset
//  valid_in   in   1       upstream block valid (from ShiftRows valid_out)
//  data_in    in   128     state; column c = data_in[127-32c -: 32], row 0 in MSB byte
//  bypass     in   1       sampled with data_in; 1 = pass state unchanged (last round)
//  inv        in   1       only when MIXCOL_INV_EN defined; 1 = InvMixColumns
//  in_ready   out  1       stage can accept a block this cycle
//  valid_out  out  1       one-cycle pulse, data_out holds a finished block
//  data_out   out  128     result state, same byte ordering as data_in
// BEHAVIOUR
//  - Reset: state=IDLE, col_cnt=0, work reg=0, valid_out=0, data_out=0; in_ready=1 next cycle.
//  - FSM IDLE: in_ready=1. Edge with valid_in=1: latch data_in/bypass(/inv) -> BUSY, col_cnt=0.
//  - BUSY: in_ready=0; each edge replaces column col_cnt of work reg with its mixed value
//    (or unchanged if bypass); col_cnt++; edge processing col 3 -> DONE (col_cnt wraps to 0).
//  - DONE: valid_out=1, data_out=work reg; in_ready=1. Edge with valid_in=1 accepts the next
//    block -> BUSY; otherwise -> IDLE. valid_out is high for exactly one cycle.
//  - Latency: valid_out asserts 4 cycles after the accepting edge. Throughput: 1 block / 5 cycles.
//  - valid_in while in_ready=0 is not accepted; upstream holds data_in/valid_in until accepted.
//  - bypass still takes the full 4-cycle path: uniform latency regardless of bypass.
//  - data_out is registered and holds the last result after DONE until the next DONE or reset.
//  - Reset mid-BUSY discards the in-flight block; no valid_out is generated for it.
//  - Arithmetic: GF(2^8) mod x^8+x^4+x^3+x+1; forward matrix rows {02 03 01 01} rotated;
//    xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00).
// CONFIGURATION
//  MIXCOL_INV_EN defined: port inv exists, sampled at accept; inv=1 uses the inverse matrix
//    {0e 0b 0d 09} rotated; bypass has priority over inv.
//  MIXCOL_INV_EN undefined: no inv port, forward MixColumns only; inverse logic not built.
// STRUCTURE
//  - aes_pkg: BYTE_W=8, NB, COL_W=32, AES_POLY=8'h1b, functions xtime, gmul2, gmul3
//    (+ gmul9/11/13/14 under MIXCOL_INV_EN); shared with other round stages.
//  - Sub-module mix_single_column: combinational 32-bit column in -> 32-bit column out, inv input;
//    one instance, muxed by col_cnt. FSM, counter and work register stay in mix_columns.
// TESTING
//  1 FIPS-197 vector: data_in=128'hdb135345_f20a225c_01010101_c6c6c6c6, bypass=0 ->
//    data_out=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, valid_out 4 cycles after accept.
//  2 data_in=128'hd4d4d4d5_2d26314c_00000000_ffffffff -> data_out=128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff.
//  3 bypass=1 with vector 1 -> data_out equals data_in, same 4-cycle latency.
//  4 valid_in held high over two blocks -> accepts 5 cycles apart, in_ready low exactly 4 cycles
//    per block, two valid_out pulses 5 cycles apart, outputs in order.
//  5 reset asserted in 2nd BUSY cycle -> no valid_out, data_out=0, in_ready=1 next cycle.
//  6 MIXCOL_INV_EN, inv=1, data_in=128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6 ->
//    data_out=128'hdb135345_f20a225c_01010101_c6c6c6c6.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: byte/column geometry, field polynomial and GF(2^8) helpers.
// The inverse-matrix multipliers exist only when MIXCOL_INV_EN is defined.
package aes_pkg;

  localparam int          BYTE_W   = 8;
  localparam int          NB       = 4;
  localparam int          COL_W    = NB * BYTE_W;
  localparam logic [7:0]  AES_POLY = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

`ifdef MIXCOL_INV_EN
  // Inverse coefficients built from x^1, x^2, x^3 multiples of the operand.
  function automatic logic [7:0] gmul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction
`endif

endpackage

// File: rtl/mix_columns_mix_single_column.sv
// Combinational MixColumns of one 32-bit column (row 0 in the MSB byte).
// With MIXCOL_INV_EN defined an inv_i input selects the inverse matrix.
module mix_single_column
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
`ifdef MIXCOL_INV_EN
  input  logic             inv_i,
`endif
  output logic [COL_W-1:0] col_o
);

  logic [0:NB-1][BYTE_W-1:0] a;
  logic [0:NB-1][BYTE_W-1:0] b;

  assign a     = col_i;
  assign col_o = b;

  // Each output row is the same coefficient set rotated by the row index.
  for (genvar r = 0; r < NB; r++) begin : g_row
    logic [BYTE_W-1:0] fwd;
    assign fwd = gmul2(a[r]) ^ gmul3(a[(r + 1) % NB]) ^ a[(r + 2) % NB] ^ a[(r + 3) % NB];
`ifdef MIXCOL_INV_EN
    logic [BYTE_W-1:0] inv;
    assign inv  = gmul14(a[r]) ^ gmul11(a[(r + 1) % NB]) ^
                  gmul13(a[(r + 2) % NB]) ^ gmul9(a[(r + 3) % NB]);
    assign b[r] = inv_i ? inv : fwd;
`else
    assign b[r] = fwd;
`endif
  end

endmodule

// File: rtl/mix_columns.sv
// Column-serial AES MixColumns stage: one column per clock, per-block bypass.
// Define MIXCOL_INV_EN to add the inv port and InvMixColumns support.
module mix_columns #(
  parameter int DATA_W = 128,
  parameter int NB     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              bypass,
`ifdef MIXCOL_INV_EN
  input  logic              inv,
`endif
  output logic              in_ready,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out
);

  import aes_pkg::*;

  if (DATA_W != 128 || NB != aes_pkg::NB) begin : g_bad_cfg
    $error("mix_columns supports only DATA_W=128, NB=4");
  end

  mc_state_e         state_q, state_d;
  logic [1:0]        col_cnt_q, col_cnt_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              byp_q, byp_d;
  logic [COL_W-1:0]  col_in, col_mixed;
`ifdef MIXCOL_INV_EN
  logic              inv_q, inv_d;
`endif

  always_comb begin
    col_in = '0;
    for (int c = 0; c < NB; c++) begin
      if (col_cnt_q == 2'(c)) col_in = work_q[DATA_W-1-COL_W*c -: COL_W];
    end
  end

  mix_single_column u_mix (
    .col_i (col_in),
`ifdef MIXCOL_INV_EN
    .inv_i (inv_q),
`endif
    .col_o (col_mixed)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    work_d    = work_q;
    data_d    = data_q;
    byp_d     = byp_q;
`ifdef MIXCOL_INV_EN
    inv_d     = inv_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (valid_in) begin
          work_d    = data_in;
          byp_d     = bypass;
`ifdef MIXCOL_INV_EN
          inv_d     = inv;
`endif
          col_cnt_d = 2'd0;
          state_d   = ST_BUSY;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Bypassed blocks still walk all four columns so latency stays uniform.
        if (!byp_q) begin
          for (int c = 0; c < NB; c++) begin
            if (col_cnt_q == 2'(c)) work_d[DATA_W-1-COL_W*c -: COL_W] = col_mixed;
          end
        end
        col_cnt_d = col_cnt_q + 2'd1;
        if (col_cnt_q == 2'(NB - 1)) begin
          data_d  = work_d;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the work and output registers are reset too, so a discarded block never leaks to data_out.
      state_q   <= ST_IDLE;
      col_cnt_q <= 2'd0;
      work_q    <= '0;
      data_q    <= '0;
      byp_q     <= 1'b0;
`ifdef MIXCOL_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates make all registers change together at the edge.
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      work_q    <= work_d;
      data_q    <= data_d;
      byp_q     <= byp_d;
`ifdef MIXCOL_INV_EN
      inv_q     <= inv_d;
`endif
    end
  end

  assign in_ready  = (state_q != ST_BUSY);
  assign valid_out = (state_q == ST_DONE);
  assign data_out  = data_q;

endmodule

// File: tb/tb_mix_columns.sv
// Self-checking bench for mix_columns: vector table, scoreboard queue, and
// hand-written back-to-back and mid-block reset sequences.
module tb_mix_columns;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic [127:0] data_in;
  logic         bypass;
`ifdef MIXCOL_INV_EN
  logic         inv;
`endif
  logic         in_ready;
  logic         valid_out;
  logic [127:0] data_out;

  mix_columns dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .bypass    (bypass),
`ifdef MIXCOL_INV_EN
    .inv       (inv),
`endif
    .in_ready  (in_ready),
    .valid_out (valid_out),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] din;
    logic         byp;
    logic         inv;
    logic [127:0] exp;
  } vec_t;

  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  int           vo_cnt   = 0;
  logic [127:0] sb_q[$];
  int           vo_times[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every valid_out pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && valid_out === 1'b1) begin
      vo_cnt++;
      vo_times.push_back(cyc);
      if (sb_q.size() == 0) check("unexpected valid_out", 128'd1, 128'd0);
      else check("data_out", data_out, sb_q.pop_front());
    end
  end

  // Called right after a negedge with valid_in already driven; returns the accepting cycle.
  task automatic wait_accept(output int t);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("accept timeout", 128'd0, 128'd1);
      $display("FAIL accept timeout: in_ready never rose");
      $fatal(1, "timeout");
    end
    @(posedge clk);
    #1;
    t = cyc;
  endtask

  task automatic run_block(input vec_t v, input string name);
    int t, lat, low;
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = v.din;
    bypass   = v.byp;
`ifdef MIXCOL_INV_EN
    inv      = v.inv;
`endif
    sb_q.push_back(v.exp);
    wait_accept(t);
    valid_in = 1'b0;
    lat = 0;
    low = 0;
    forever begin
      @(negedge clk);
      if (valid_out === 1'b1 || lat >= 10) break;
      if (in_ready === 1'b0) low++;
      @(posedge clk);
      lat++;
    end
    check({name, " latency"}, 128'(lat), 128'd4);
    check({name, " in_ready low cycles"}, 128'(low), 128'd4);
    @(negedge clk);
    check({name, " valid_out one cycle"}, {127'd0, valid_out}, 128'd0);
    check({name, " data_out held"}, data_out, v.exp);
  endtask

  localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

  initial begin
    vec_t vecs[$];
    int   t0, t1, low, n, vo_before;

    vecs.push_back('{V1_IN, 1'b0, 1'b0, V1_OUT});
    vecs.push_back('{V2_IN, 1'b0, 1'b0, V2_OUT});
    vecs.push_back('{V1_IN, 1'b1, 1'b0, V1_IN});
    vecs.push_back('{V2_IN, 1'b1, 1'b0, V2_IN});
    vecs.push_back('{128'h01010101_c6c6c6c6_db135345_f20a225c, 1'b0, 1'b0,
                     128'h01010101_c6c6c6c6_8e4da1bc_9fdc589d});
`ifdef MIXCOL_INV_EN
    vecs.push_back('{V1_OUT, 1'b0, 1'b1, V1_IN});
    vecs.push_back('{V2_OUT, 1'b0, 1'b1, V2_IN});
    vecs.push_back('{V1_OUT, 1'b1, 1'b1, V1_OUT});
`endif

    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    bypass   = 1'b0;
`ifdef MIXCOL_INV_EN
    inv      = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset valid_out", {127'd0, valid_out}, 128'd0);
    check("reset data_out", data_out, 128'd0);
    check("reset in_ready", {127'd0, in_ready}, 128'd1);

    foreach (vecs[i]) run_block(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: valid_in held high across two blocks.
    vo_times.delete();
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = V1_IN;
    bypass   = 1'b0;
`ifdef MIXCOL_INV_EN
    inv      = 1'b0;
`endif
    sb_q.push_back(V1_OUT);
    wait_accept(t0);
    data_in = V2_IN;
    sb_q.push_back(V2_OUT);
    low = 0;
    n   = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      low++;
      n++;
      @(negedge clk);
    end
    check("b2b in_ready low cycles", 128'(low), 128'd4);
    wait_accept(t1);
    valid_in = 1'b0;
    check("b2b accept spacing", 128'(t1 - t0), 128'd5);
    repeat (8) @(negedge clk);
    check("b2b valid_out count", 128'(vo_times.size()), 128'd2);
    if (vo_times.size() >= 2)
      check("b2b valid_out spacing", 128'(vo_times[1] - vo_times[0]), 128'd5);
    check("b2b scoreboard drained", 128'(sb_q.size()), 128'd0);

    // Reset during the second BUSY cycle discards the block.
    vo_before = vo_cnt;
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = V2_IN;
    wait_accept(t0);
    valid_in = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid reset valid_out", {127'd0, valid_out}, 128'd0);
    check("mid reset data_out", data_out, 128'd0);
    check("mid reset in_ready", {127'd0, in_ready}, 128'd1);
    repeat (8) @(negedge clk);
    check("mid reset no pulse", 128'(vo_cnt - vo_before), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
